mem_port_arbiter: RTL

- Shares one single-port, fixed-latency main-memory port between the instruction-cache refill path (I side) and the data-cache refill/write-back path (D side).
- Sequences each granted line as a burst of word accesses.
- Drives the ICacheMiss/DCacheMiss stall inputs of the hazard unit, which are currently tied low.
- Sits between the I/D cache controllers and the main-memory model, beside the core top level.

---
 rtl/mem_port_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency, single-port main memory between
// the I-cache refill path and the D-cache refill/write-back path. Each grant
// runs one line as a burst of LINE_WORDS word accesses, each MEM_LATENCY cycles.
// Build option: define MEM_ARB_DPRIO_EN for fixed D-side priority on ties;
// the default build arbitrates ties round-robin.
module mem_port_arbiter #(
   parameter int unsigned LINE_WORDS  = 4,
   parameter int unsigned MEM_LATENCY = 3
) (
   input  logic        CPU_CLK,
   input  logic        CPU_RST_N,
   // I side
   input  logic        I_Req,
   input  logic [31:0] I_Addr,
   output logic        I_Gnt,
   output logic        I_RValid,
   output logic [31:0] I_RData,
   output logic        I_Done,
   // D side
   input  logic        D_Req,
   input  logic        D_We,
   input  logic [31:0] D_Addr,
   input  logic [31:0] D_WData,
   output logic        D_Gnt,
   output logic        D_RValid,
   output logic [31:0] D_RData,
   output logic        D_WReady,
   output logic        D_Done,
   // memory port
   output logic [31:0] Mem_Addr,
   output logic        Mem_Re,
   output logic        Mem_We,
   output logic [31:0] Mem_WData,
   input  logic [31:0] Mem_RData,
   // hazard-unit stall inputs
   output logic        ICacheMiss,
   output logic        DCacheMiss
);

   localparam int unsigned WCNT_W = $clog2(LINE_WORDS);
   localparam int unsigned LCNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int unsigned OFFS_W = WCNT_W + 2;

   // clears the byte-in-line offset so every burst starts at word 0 of the line
   localparam logic [31:0]       BASE_MASK = ~((32'd1 << OFFS_W) - 32'd1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(LINE_WORDS - 1);
   localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(MEM_LATENCY - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   state_t            r_state;
   owner_t            r_owner;
   logic [31:0]       r_base;
   logic              r_we;
   logic [WCNT_W-1:0] r_wcnt;
   logic [LCNT_W-1:0] r_lcnt;
   logic              r_i_gnt;
   logic              r_d_gnt;
`ifndef MEM_ARB_DPRIO_EN
   owner_t            r_last_gnt;
   owner_t            w_last_gnt_nxt;
`endif

   state_t            w_state_nxt;
   owner_t            w_owner_nxt;
   logic [31:0]       w_base_nxt;
   logic              w_we_nxt;
   logic [WCNT_W-1:0] w_wcnt_nxt;
   logic [LCNT_W-1:0] w_lcnt_nxt;
   logic              w_i_gnt_nxt;
   logic              w_d_gnt_nxt;

   logic              w_pick_d;
   logic              w_burst;
   logic              w_word_end;
   logic              w_line_end;
   logic              w_own_i;
   logic              w_own_d;

   // burst-phase decodes shared by the strobe and handshake outputs
   assign w_burst    = (r_state == S_BURST);
   assign w_word_end = w_burst && (r_lcnt == LCNT_LAST);
   assign w_line_end = w_word_end && (r_wcnt == WCNT_LAST);
   assign w_own_i    = (r_owner == OWN_I);
   assign w_own_d    = (r_owner == OWN_D);

   // arbitration: choose D when it is alone, or when it wins a tie
   always_comb begin
      w_pick_d = 1'b0;
`ifdef MEM_ARB_DPRIO_EN
      w_pick_d = D_Req;
`else
      if (D_Req && I_Req) begin
         w_pick_d = (r_last_gnt == OWN_I);
      end else begin
         w_pick_d = D_Req;
      end
`endif
   end

   // state register and burst bookkeeping
   always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
      if (!CPU_RST_N) begin
         r_state    <= S_IDLE;
         r_owner    <= OWN_I;
         r_base     <= '0;
         r_we       <= 1'b0;
         r_wcnt     <= '0;
         r_lcnt     <= '0;
         r_i_gnt    <= 1'b0;
         r_d_gnt    <= 1'b0;
`ifndef MEM_ARB_DPRIO_EN
         r_last_gnt <= OWN_I;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_base     <= w_base_nxt;
         r_we       <= w_we_nxt;
         r_wcnt     <= w_wcnt_nxt;
         r_lcnt     <= w_lcnt_nxt;
         r_i_gnt    <= w_i_gnt_nxt;
         r_d_gnt    <= w_d_gnt_nxt;
`ifndef MEM_ARB_DPRIO_EN
         r_last_gnt <= w_last_gnt_nxt;
`endif
      end
   end

   // next-state: latch the winner in IDLE, step word/latency counters in BURST
   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_base_nxt     = r_base;
      w_we_nxt       = r_we;
      w_wcnt_nxt     = r_wcnt;
      w_lcnt_nxt     = r_lcnt;
      w_i_gnt_nxt    = 1'b0;
      w_d_gnt_nxt    = 1'b0;
`ifndef MEM_ARB_DPRIO_EN
      w_last_gnt_nxt = r_last_gnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (I_Req || D_Req) begin
               w_state_nxt    = S_BURST;
               w_owner_nxt    = w_pick_d ? OWN_D : OWN_I;
               w_we_nxt       = w_pick_d & D_We;
               w_base_nxt     = (w_pick_d ? D_Addr : I_Addr) & BASE_MASK;
               w_wcnt_nxt     = '0;
               w_lcnt_nxt     = '0;
               w_i_gnt_nxt    = ~w_pick_d;
               w_d_gnt_nxt    = w_pick_d;
`ifndef MEM_ARB_DPRIO_EN
               w_last_gnt_nxt = w_pick_d ? OWN_D : OWN_I;
`endif
            end
         end
         S_BURST: begin
            if (w_word_end) begin
               w_lcnt_nxt = '0;
               w_wcnt_nxt = r_wcnt + WCNT_W'(1);
               if (w_line_end) begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_lcnt_nxt = r_lcnt + LCNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // memory port: address and strobes held for each whole word period
   assign Mem_Addr  = w_burst ? (r_base + 32'({r_wcnt, 2'b00})) : 32'd0;
   assign Mem_Re    = w_burst & ~r_we;
   assign Mem_We    = w_burst & r_we;
   assign Mem_WData = D_WData;

   // requester handshakes, qualified by the current owner
   assign I_Gnt     = r_i_gnt;
   assign D_Gnt     = r_d_gnt;
   assign I_RValid  = w_word_end & ~r_we & w_own_i;
   assign D_RValid  = w_word_end & ~r_we & w_own_d;
   assign D_WReady  = w_word_end & r_we & w_own_d;
   assign I_Done    = w_line_end & w_own_i;
   assign D_Done    = w_line_end & w_own_d;
   assign I_RData   = Mem_RData;
   assign D_RData   = Mem_RData;

   // stall requests to the hazard unit
   assign ICacheMiss = I_Req & ~I_Done;
   assign DCacheMiss = D_Req & ~D_Done;

endmodule
